// File: rtl/keypad_scan_if.sv
// Keypad pin and key-report bundle for keypad_scan.
// master: the scanner side; slave: board pins / consuming datapath side.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;

  modport master (input row, output col, output key, output key_valid, output key_down);
  modport slave  (output row, input col, input key, input key_valid, input key_down);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 low-active matrix keypad scanner with whole-scan debounce and one-cycle key strobe.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_SCAN_REPEAT_EN.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master kp
);
  localparam int unsigned DW      = $clog2(SCAN_DIV);
  localparam int unsigned CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    col_q;
  logic          last_dwell, scan_done;
  logic          col_hit;
  logic [1:0]    col_row;
  logic          scan_hit, hit;
  logic [3:0]    scan_code, code;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    cand, cand_nxt, key_q, key_nxt;
  logic          valid_q, valid_nxt, down_q, down_nxt;

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    case (idx)
      2'd0:    col_decode = 4'b1110;
      2'd1:    col_decode = 4'b1101;
      2'd2:    col_decode = 4'b1011;
      default: col_decode = 4'b0111;
    endcase
  endfunction

  // Lowest row index pulled low in the currently driven column
  always_comb begin
    col_hit = 1'b0;
    col_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        col_hit = 1'b1;
        col_row = 2'(r);
      end
    end
  end

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign scan_done  = last_dwell && (col_idx == 2'd3);
  // First hit of the scan wins; the column sampled this cycle only counts if none yet
  assign hit        = scan_hit || (last_dwell && col_hit);
  assign code       = scan_hit ? scan_code : {col_row, col_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      dwell     <= '0;
      col_idx   <= 2'd0;
      col_q     <= 4'b1110;
      scan_hit  <= 1'b0;
      scan_code <= 4'h0;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
      if (last_dwell) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        col_q   <= col_decode(col_idx + 2'd1);
        if (scan_done) begin
          scan_hit  <= 1'b0;
          scan_code <= 4'h0;
        end else begin
          scan_hit  <= hit;
          scan_code <= code;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  assign cnt_inc = (cnt == CW'(CNT_MAX)) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      cnt     <= '0;
      cand    <= 4'h0;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cand    <= cand_nxt;
      key_q   <= key_nxt;
      valid_q <= valid_nxt;
      down_q  <= down_nxt;
    end
  end

  // Debounce FSM: advances only once per full scan
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    key_nxt   = key_q;
    valid_nxt = 1'b0;
    down_nxt  = down_q;
    if (scan_done) begin
      case (state)
        SCAN: begin
          if (hit) begin
            state_nxt = DEBOUNCE;
            cand_nxt  = code;
            cnt_nxt   = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (hit && code == cand) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_nxt = PRESSED;
              key_nxt   = cand;
              valid_nxt = 1'b1;
              down_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (!(hit && code == key_q)) begin
            state_nxt = RELEASE;
            cnt_nxt   = CW'(1);
          end
`ifdef KEYPAD_SCAN_REPEAT_EN
          else if (cnt_inc == CW'(REPEAT_SCANS)) begin
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
`endif
        end
        RELEASE: begin
          if (hit && code == key_q) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
            down_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  assign kp.col       = col_q;
  assign kp.key       = key_q;
  assign kp.key_valid = valid_q;
  assign kp.key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives rows from col, and a scan-level
// reference model predicts col/key/key_valid/key_down every cycle.
module tb_keypad_scan;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned REP      = 4;
  localparam int unsigned SCAN_LEN = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] held = 16'h0;
  logic [3:0]  row_drv;

  int n_vec = 0;
  int n_err = 0;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif.master)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts row r to column c; bit r*4+c of held
  always_comb begin
    for (int r = 0; r < 4; r++) row_drv[r] = ~|(held[r*4 +: 4] & ~kif.col);
  end
  assign kif.row = row_drv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: position within the scan, and scan-level press bookkeeping
  int   ph = 0;
  bit   live = 0;
  bit   m_down = 0;
  bit   m_valid = 0;
  int   m_key = 0;
  int   run_len = 0;
  int   run_code = 0;
  int   absent = 0;
  int   rep = 0;

  task automatic scan_eval(input logic [15:0] mask);
    bit hit = 0;
    int code = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!hit && mask[r*4+c]) begin hit = 1; code = r*4 + c; end
    if (!m_down) begin
      if (run_len > 0) begin
        if (hit && code == run_code) run_len++;
        else run_len = 0;
      end else if (hit) begin
        run_len  = 1;
        run_code = code;
      end
      if (run_len == DEB) begin
        m_down = 1; m_key = run_code; m_valid = 1;
        run_len = 0; rep = 0; absent = 0;
      end
    end else if (hit && code == m_key) begin
      if (absent > 0) begin
        absent = 0; rep = 0;
      end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
        rep++;
        if (rep == REP) begin m_valid = 1; rep = 0; end
`endif
      end
    end else begin
      absent++;
      rep = 0;
      if (absent == DEB) begin m_down = 0; absent = 0; end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      live = 1; ph = 0; m_down = 0; m_valid = 0; m_key = 0;
      run_len = 0; run_code = 0; absent = 0; rep = 0;
    end else begin
      m_valid = 0;
      if (ph == SCAN_LEN - 1) scan_eval(held);
      ph = (ph + 1) % SCAN_LEN;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << (ph / SCAN_DIV));
      check_eq("col", 32'(kif.col), 32'(ec));
      check_eq("key", 32'(kif.key), 32'(m_key[3:0]));
      check_eq("key_valid", 32'(kif.key_valid), 32'(m_valid));
      check_eq("key_down", 32'(kif.key_down), 32'(m_down));
    end
  end

  // All tasks start and end just after a falling edge
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_scan(input logic [15:0] mask, input int n);
    held = mask;
    repeat (n * SCAN_LEN) @(negedge clk);
  endtask

  initial begin
    logic [15:0] m;
    int sel;
    @(negedge clk);
    do_reset();
    run_scan(16'h0, 2);
    // Clean press of (row1,col2) then release
    run_scan(16'h1 << 6, 5);
    run_scan(16'h0, 4);
    // Bounce: only two scans held
    run_scan(16'h1 << 6, 2);
    run_scan(16'h0, 3);
    // Two keys: (row3,col0) wins over (row0,col2)
    run_scan((16'h1 << 12) | (16'h1 << 2), 5);
    run_scan(16'h0, 4);
    // Reset while pressed with the key still held
    run_scan(16'h1 << 6, 4);
    repeat (7) @(negedge clk);
    do_reset();
    run_scan(16'h1 << 6, 12);
    run_scan(16'h0, 4);
    // Randomized key activity with occasional mid-scan resets
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) m = 16'h0;
      else if (sel < 8) m = 16'h1 << $urandom_range(0, 15);
      else m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        held = m;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        do_reset();
      end else begin
        run_scan(m, $urandom_range(1, 7));
      end
    end
    run_scan(16'h0, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
